// File: rtl/rk8e_data_break_if.sv
// rk8e_data_break_if: RK8-E request/response, CPU data-break handshake
// and main-memory port of the data-break controller.
interface rk8e_data_break_if;
  logic        req_valid;
  logic        req_ready;
  logic [0:14] req_addr;
  logic        req_to_mem;
  logic [0:11] req_wdata;
  logic        rsp_done;
  logic [0:11] rsp_rdata;
  logic        brk_req;
  logic        brk_gnt;
  logic [0:14] mem_addr;
  logic [0:11] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [0:11] mem_rdata;
  logic        late_err;

  // Data-break controller side.
  modport slave (
    input  req_valid, req_addr, req_to_mem, req_wdata, brk_gnt, mem_rdata,
    output req_ready, rsp_done, rsp_rdata, brk_req, mem_addr, mem_wdata,
           mem_we, mem_re, late_err
  );

  // RK8-E / CPU / memory side.
  modport master (
    output req_valid, req_addr, req_to_mem, req_wdata, brk_gnt, mem_rdata,
    input  req_ready, rsp_done, rsp_rdata, brk_req, mem_addr, mem_wdata,
           mem_we, mem_re, late_err
  );
endinterface

// File: rtl/rk8e_data_break.sv
// rk8e_data_break: queues RK8-E word transfers, requests a data break and
// runs one ADDR/XFER/CAPT/DONE memory cycle per queued word while granted.
// Optional grant-late watchdog enabled by defining RK8E_DB_LATE_EN.
module rk8e_data_break #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned LATE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  rk8e_data_break_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

`ifdef RK8E_DB_LATE_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [0:14] addr;
    logic        to_mem;
    logic [0:11] wdata;
  } entry_t;

  typedef enum logic [2:0] {IDLE, ADDR, XFER, CAPT, DONE} state_t;

  logic          r_rst_meta;
  logic          r_rst_sync;
  state_t        r_state;
  state_t        w_state_next;
  entry_t        r_fifo [DEPTH];
  entry_t        w_head;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          r_brk_req;
  logic [0:14]   r_mem_addr;
  logic [0:11]   r_mem_wdata;
  logic [0:11]   r_rsp_rdata;
  logic          w_mem_we;
  logic          w_mem_re;
  logic          w_rsp_done;
  logic [15:0]   r_wait_cnt;
  logic          w_waiting;
  logic          w_late_drop;
  logic          r_late_err;

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = bus.req_valid && !w_full && !clear;
  assign w_waiting   = LATE_EN && !clear && (r_state == IDLE) &&
                       (r_count != '0) && !bus.brk_gnt;
  assign w_late_drop = w_waiting && (r_wait_cnt == 16'(LATE_CYCLES - 1));
  assign w_pop       = !clear && ((r_state == DONE) || w_late_drop);

  // Reset asserts asynchronously, releases two clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) r_state <= IDLE;
    else             r_state <= w_state_next;
  end

  // Next state and memory/response strobes; clear wins over everything.
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      IDLE: if ((r_count != '0) && bus.brk_gnt) w_state_next = ADDR;
      ADDR: w_state_next = XFER;
      XFER: begin
        w_mem_we     = w_head.to_mem;
        w_mem_re     = !w_head.to_mem;
        w_state_next = CAPT;
      end
      CAPT: w_state_next = DONE;
      DONE: begin
        w_rsp_done   = 1'b1;
        w_state_next = ((w_count_next != '0) && bus.brk_gnt) ? ADDR : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (clear) begin
      w_state_next = IDLE;
      w_mem_we     = 1'b0;
      w_mem_re     = 1'b0;
      w_rsp_done   = 1'b0;
    end
  end

  // FIFO occupancy after this cycle's push/pop/flush.
  always_comb begin
    w_count_next = r_count;
    if (clear)                w_count_next = '0;
    else if (w_push && !w_pop) w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
  end

  // FIFO pointers and count.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {bus.req_addr, bus.req_to_mem, bus.req_wdata};
  end

  // Break request, held memory address/data and captured read word.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_brk_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_brk_req <= (w_count_next != '0);
      if (r_state == ADDR) begin
        r_mem_addr  <= w_head.addr;
        r_mem_wdata <= w_head.wdata;
      end
      if ((r_state == CAPT) && !w_head.to_mem && !clear) r_rsp_rdata <= bus.mem_rdata;
    end
  end

  // Grant-wait watchdog; counts only while a request waits ungranted in IDLE.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_wait_cnt <= '0;
      r_late_err <= 1'b0;
    end else begin
      if (!w_waiting || w_late_drop) r_wait_cnt <= '0;
      else                           r_wait_cnt <= r_wait_cnt + 1'b1;
      if (clear)            r_late_err <= 1'b0;
      else if (w_late_drop) r_late_err <= 1'b1;
    end
  end

  // Address/data come straight from the head in ADDR, from the hold regs after.
  assign bus.mem_addr  = (r_state == ADDR) ? w_head.addr  : r_mem_addr;
  assign bus.mem_wdata = (r_state == ADDR) ? w_head.wdata : r_mem_wdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_re    = w_mem_re;
  assign bus.rsp_done  = w_rsp_done;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.req_ready = !w_full;
  assign bus.brk_req   = r_brk_req;
  assign bus.late_err  = r_late_err;

endmodule

// File: tb/tb_rk8e_data_break.sv
// tb_rk8e_data_break: directed checks of the data-break controller with a
// small behavioural main memory.
module tb_rk8e_data_break;
  logic clk = 1'b0;
  logic reset;
  logic clear;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_we = 0;
  int n_re = 0;
  int n_done = 0;
  int last_done = 0;
  int prev_done = 0;
  logic [11:0] mem [0:32767];

  rk8e_data_break_if bus ();

  rk8e_data_break #(.DEPTH(2), .LATE_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model and strobe bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      n_we <= n_we + 1;
    end
    if (bus.mem_re) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      n_re <= n_re + 1;
    end
    if (bus.rsp_done) begin
      n_done    <= n_done + 1;
      prev_done <= last_done;
      last_done <= cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_begin(input logic [14:0] a, input logic tm, input logic [11:0] d);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_to_mem = tm;
    bus.req_wdata  = d;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick; tick; tick;
    n_checks++;
    if ({bus.req_ready, bus.rsp_done, bus.rsp_rdata, bus.brk_req, bus.mem_addr, bus.mem_wdata,
         bus.mem_we, bus.mem_re, bus.late_err} !== {1'b1, 1'b0, 12'o0, 1'b0, 15'o0, 12'o0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b done=%b rdata=%o brk=%b addr=%o wdata=%o we=%b re=%b late=%b, required 1 0 0 0 0 0 0 0 0",
               bus.req_ready, bus.rsp_done, bus.rsp_rdata, bus.brk_req, bus.mem_addr, bus.mem_wdata,
               bus.mem_we, bus.mem_re, bus.late_err);
    end
    reset = 1'b1;
    tick; tick;
  endtask

  task automatic test_single_write;
    push_begin(15'o12345, 1'b1, 12'o7070);
    tick;
    bus.req_valid = 1'b0;
    n_checks++;
    if ({bus.brk_req, bus.req_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_brk_req: got brk=%b rdy=%b, required 1 1", bus.brk_req, bus.req_ready);
    end
    bus.brk_gnt = 1'b1;
    tick;
    n_checks++;
    if ({bus.mem_we, bus.mem_re, bus.mem_addr} !== {1'b0, 1'b0, 15'o12345}) begin
      n_fail++;
      $display("FAIL wr_addr_phase: got we=%b re=%b addr=%o, required 0 0 12345", bus.mem_we, bus.mem_re, bus.mem_addr);
    end
    tick;
    n_checks++;
    if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 15'o12345, 12'o7070}) begin
      n_fail++;
      $display("FAIL wr_strobe: got we=%b re=%b addr=%o wdata=%o, required 1 0 12345 7070",
               bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
    end
    bus.brk_gnt = 1'b0;
    tick;
    n_checks++;
    if ({bus.mem_we, bus.rsp_done, bus.mem_addr} !== {1'b0, 1'b0, 15'o12345}) begin
      n_fail++;
      $display("FAIL wr_capt: got we=%b done=%b addr=%o, required 0 0 12345", bus.mem_we, bus.rsp_done, bus.mem_addr);
    end
    tick;
    n_checks++;
    if ({bus.rsp_done, bus.rsp_rdata} !== {1'b1, 12'o0}) begin
      n_fail++;
      $display("FAIL wr_done: got done=%b rdata=%o, required 1 0", bus.rsp_done, bus.rsp_rdata);
    end
    tick;
    n_checks++;
    if ({bus.rsp_done, bus.brk_req, bus.req_ready, mem[15'o12345]} !== {1'b0, 1'b0, 1'b1, 12'o7070}) begin
      n_fail++;
      $display("FAIL wr_after: got done=%b brk=%b rdy=%b mem=%o, required 0 0 1 7070",
               bus.rsp_done, bus.brk_req, bus.req_ready, mem[15'o12345]);
    end
  endtask

  task automatic test_single_read;
    int base_re;
    base_re = n_re;
    bus.brk_gnt = 1'b1;
    push_begin(15'o00200, 1'b0, 12'o0);
    tick;
    bus.req_valid = 1'b0;
    tick;
    tick;
    n_checks++;
    if ({bus.mem_we, bus.mem_re, bus.mem_addr} !== {1'b0, 1'b1, 15'o00200}) begin
      n_fail++;
      $display("FAIL rd_strobe: got we=%b re=%b addr=%o, required 0 1 200", bus.mem_we, bus.mem_re, bus.mem_addr);
    end
    tick;
    tick;
    n_checks++;
    if ({bus.rsp_done, bus.rsp_rdata} !== {1'b1, 12'o4321}) begin
      n_fail++;
      $display("FAIL rd_done: got done=%b rdata=%o, required 1 4321", bus.rsp_done, bus.rsp_rdata);
    end
    tick;
    bus.brk_gnt = 1'b0;
    n_checks++;
    if ({bus.rsp_done, bus.rsp_rdata, 32'(n_re - base_re)} !== {1'b0, 12'o4321, 32'd1}) begin
      n_fail++;
      $display("FAIL rd_hold: got done=%b rdata=%o re_pulses=%0d, required 0 4321 1",
               bus.rsp_done, bus.rsp_rdata, n_re - base_re);
    end
  endtask

  task automatic test_full_fifo;
    int base_done;
    push_begin(15'o00300, 1'b1, 12'o1111);
    tick;
    push_begin(15'o00301, 1'b1, 12'o2222);
    tick;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got rdy=%b, required 0", bus.req_ready);
    end
    push_begin(15'o00302, 1'b1, 12'o3333);
    tick;
    bus.req_valid = 1'b0;
    base_done = n_done;
    bus.brk_gnt = 1'b1;
    for (int i = 0; i < 12; i++) tick;
    bus.brk_gnt = 1'b0;
    n_checks++;
    if ({32'(n_done - base_done), 32'(last_done - prev_done)} !== {32'd2, 32'd4}) begin
      n_fail++;
      $display("FAIL full_b2b: got pulses=%0d spacing=%0d, required 2 4", n_done - base_done, last_done - prev_done);
    end
    n_checks++;
    if ({mem[15'o00300], mem[15'o00301], mem[15'o00302], bus.brk_req} !== {12'o1111, 12'o2222, 12'o0, 1'b0}) begin
      n_fail++;
      $display("FAIL full_mem: got %o %o %o brk=%b, required 1111 2222 0 0",
               mem[15'o00300], mem[15'o00301], mem[15'o00302], bus.brk_req);
    end
  endtask

  task automatic test_grant_drop;
    int base_we;
    int base_done;
    push_begin(15'o01000, 1'b1, 12'o5555);
    tick;
    push_begin(15'o01001, 1'b1, 12'o6666);
    tick;
    bus.req_valid = 1'b0;
    bus.brk_gnt = 1'b1;
    tick;
    tick;
    n_checks++;
    if ({bus.mem_we, bus.mem_addr} !== {1'b1, 15'o01000}) begin
      n_fail++;
      $display("FAIL drop_xfer: got we=%b addr=%o, required 1 1000", bus.mem_we, bus.mem_addr);
    end
    bus.brk_gnt = 1'b0;
    tick;
    tick;
    n_checks++;
    if (bus.rsp_done !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_done: got done=%b, required 1", bus.rsp_done);
    end
    base_we = n_we;
    for (int i = 0; i < 6; i++) tick;
    n_checks++;
    if ({32'(n_we - base_we), bus.brk_req, mem[15'o01001]} !== {32'd0, 1'b1, 12'o0}) begin
      n_fail++;
      $display("FAIL drop_wait: got writes=%0d brk=%b mem=%o, required 0 1 0", n_we - base_we, bus.brk_req, mem[15'o01001]);
    end
    base_done = n_done;
    bus.brk_gnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (n_done != base_done) break;
    end
    bus.brk_gnt = 1'b0;
    n_checks++;
    if ({32'(n_done - base_done), mem[15'o01001]} !== {32'd1, 12'o6666}) begin
      n_fail++;
      $display("FAIL drop_resume: got pulses=%0d mem=%o, required 1 6666", n_done - base_done, mem[15'o01001]);
    end
    tick;
  endtask

  task automatic test_clear;
    int base_done;
    push_begin(15'o02000, 1'b0, 12'o0);
    tick;
    push_begin(15'o02001, 1'b0, 12'o0);
    tick;
    bus.req_valid = 1'b0;
    bus.brk_gnt = 1'b1;
    tick;
    tick;
    tick;
    base_done = n_done;
    clear = 1'b1;
    bus.brk_gnt = 1'b0;
    #2;
    n_checks++;
    if ({bus.mem_we, bus.mem_re, bus.rsp_done, bus.mem_addr} !== {1'b0, 1'b0, 1'b0, 15'o02000}) begin
      n_fail++;
      $display("FAIL clr_capt: got we=%b re=%b done=%b addr=%o, required 0 0 0 2000",
               bus.mem_we, bus.mem_re, bus.rsp_done, bus.mem_addr);
    end
    tick;
    clear = 1'b0;
    n_checks++;
    if ({bus.brk_req, bus.req_ready, bus.rsp_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL clr_after: got brk=%b rdy=%b done=%b, required 0 1 0", bus.brk_req, bus.req_ready, bus.rsp_done);
    end
    for (int i = 0; i < 5; i++) tick;
    n_checks++;
    if (n_done !== base_done) begin
      n_fail++;
      $display("FAIL clr_no_done: got pulses=%0d, required 0", n_done - base_done);
    end
    push_begin(15'o03000, 1'b1, 12'o7777);
    tick;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_count: got rdy=%b after one push, required 1", bus.req_ready);
    end
    push_begin(15'o03001, 1'b1, 12'o7776);
    tick;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_refill: got rdy=%b after two pushes, required 0", bus.req_ready);
    end
  endtask

  task automatic test_async_reset;
    bus.brk_gnt = 1'b1;
    tick;
    n_checks++;
    if (bus.mem_addr !== 15'o03000) begin
      n_fail++;
      $display("FAIL arst_addr: got addr=%o, required 3000", bus.mem_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_done, bus.rsp_rdata, bus.brk_req, bus.mem_addr, bus.mem_wdata,
         bus.mem_we, bus.mem_re, bus.late_err} !== {1'b1, 1'b0, 12'o0, 1'b0, 15'o0, 12'o0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL arst_values: got rdy=%b done=%b rdata=%o brk=%b addr=%o wdata=%o we=%b re=%b late=%b, required 1 0 0 0 0 0 0 0 0",
               bus.req_ready, bus.rsp_done, bus.rsp_rdata, bus.brk_req, bus.mem_addr, bus.mem_wdata,
               bus.mem_we, bus.mem_re, bus.late_err);
    end
    bus.brk_gnt = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    tick;
    n_checks++;
    if ({bus.brk_req, mem[15'o03000]} !== {1'b0, 12'o0}) begin
      n_fail++;
      $display("FAIL arst_after: got brk=%b mem=%o, required 0 0", bus.brk_req, mem[15'o03000]);
    end
  endtask

  task automatic test_late;
    int base_we;
    int base_done;
    base_we = n_we;
    base_done = n_done;
    push_begin(15'o04000, 1'b1, 12'o1234);
    tick;
    bus.req_valid = 1'b0;
`ifdef RK8E_DB_LATE_EN
    for (int i = 0; i < 7; i++) tick;
    n_checks++;
    if ({bus.late_err, bus.brk_req} !== 2'b01) begin
      n_fail++;
      $display("FAIL late_before: got late=%b brk=%b after 7 waits, required 0 1", bus.late_err, bus.brk_req);
    end
    tick;
    n_checks++;
    if ({bus.late_err, bus.brk_req, bus.req_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL late_set: got late=%b brk=%b rdy=%b after 8 waits, required 1 0 1", bus.late_err, bus.brk_req, bus.req_ready);
    end
    tick; tick; tick;
    n_checks++;
    if ({bus.late_err, 32'(n_we - base_we), 32'(n_done - base_done), mem[15'o04000]} !== {1'b1, 32'd0, 32'd0, 12'o0}) begin
      n_fail++;
      $display("FAIL late_sticky: got late=%b writes=%0d done=%0d mem=%o, required 1 0 0 0",
               bus.late_err, n_we - base_we, n_done - base_done, mem[15'o04000]);
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    n_checks++;
    if (bus.late_err !== 1'b0) begin
      n_fail++;
      $display("FAIL late_clear: got late=%b, required 0", bus.late_err);
    end
`else
    begin
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick;
        if ((bus.brk_req !== 1'b1) || (bus.late_err !== 1'b0)) bad = 1'b1;
      end
      n_checks++;
      if ({bad, 32'(n_we - base_we), 32'(n_done - base_done)} !== {1'b0, 32'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL nolate_wait: got dropped=%b writes=%0d done=%0d, required 0 0 0",
                 bad, n_we - base_we, n_done - base_done);
      end
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    n_checks++;
    if ({bus.brk_req, bus.late_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL nolate_flush: got brk=%b late=%b, required 0 0", bus.brk_req, bus.late_err);
    end
`endif
  endtask

  initial begin
    mem[15'o00200] = 12'o4321;
    mem[15'o00302] = 12'o0;
    mem[15'o01001] = 12'o0;
    mem[15'o03000] = 12'o0;
    mem[15'o04000] = 12'o0;
    clear          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_to_mem = 1'b0;
    bus.req_wdata  = '0;
    bus.brk_gnt    = 1'b0;
    test_reset;
    test_single_write;
    test_single_read;
    test_full_fifo;
    test_grant_drop;
    test_clear;
    test_async_reset;
    test_late;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
